// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
//   Digit-serial packed-BCD adder. Captures two DIGITS-wide BCD operands and a
//   carry-in on an accepted start, then runs one shared single-digit
//   add-and-correct stage over all digits, least-significant digit first.
//   The result, carry-out and invalid-digit flag are registered and held until
//   the next completion.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - request pulse, sampled only in IDLE or DONE
//   a, b  - packed BCD operands, digit 0 in [3:0]
//   cin   - decimal carry-in to digit 0
//   busy  - high while digits are being processed
//   done  - one-cycle pulse when sum/cout/err have been updated
//   sum   - registered BCD result
//   cout  - decimal carry-out of the top digit
//   err   - set if any captured operand digit was above 9
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  res;
  logic          carry;
  logic          err_run;
  logic [CW-1:0] cnt;

  logic [4:0]    t;
  logic [3:0]    dig;
  logic          dig_carry;
  logic          dig_bad;
  logic [W-1:0]  res_next;

  // Single-digit add-and-correct on the current low digits.
  always_comb begin
    t = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0000, carry};
    if (t > 5'd9) begin
      dig       = t[3:0] + 4'd6;
      dig_carry = 1'b1;
    end else begin
      dig       = t[3:0];
      dig_carry = 1'b0;
    end
    dig_bad = (a_reg[3:0] > 4'd9) || (b_reg[3:0] > 4'd9);
    // Shift-then-overwrite keeps this legal for DIGITS == 1.
    res_next           = res >> 4;
    res_next[W-1 -: 4] = dig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      res     <= '0;
      carry   <= 1'b0;
      err_run <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            carry   <= cin;
            res     <= '0;
            cnt     <= '0;
            err_run <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> 4;
          b_reg   <= b_reg >> 4;
          carry   <= dig_carry;
          res     <= res_next;
          err_run <= err_run | dig_bad;
          cnt     <= cnt + CW'(1);
          if (cnt == CW'(DIGITS - 1)) begin
            sum   <= res_next;
            cout  <= dig_carry;
            err   <= err_run | dig_bad;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Testbench for bcd_serial_add_ctrl (DIGITS = 4).
//   Driver issues operations and pushes the expected result into a scoreboard
//   queue; a monitor pops and compares on every done pulse, also checking
//   latency, busy length and output stability during RUN.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4 * D;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         er;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  int unsigned bcnt  = 0;
  logic [W-1:0] prev_sum = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Decimal reference: plain integer arithmetic for valid operands; the
  // per-digit correction rule only when invalid digits are present.
  function automatic void ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, output logic [W-1:0] s,
                                  output logic co, output logic er);
    longint unsigned vx, vy, tot, pw;
    int unsigned     c, t;
    vx = 0; vy = 0; pw = 1; er = 1'b0; s = '0;
    for (int i = 0; i < int'(D); i++)
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) er = 1'b1;
    if (!er) begin
      for (int i = int'(D) - 1; i >= 0; i--) begin
        vx = vx * 10 + longint'(x[4*i +: 4]);
        vy = vy * 10 + longint'(y[4*i +: 4]);
        pw = pw * 10;
      end
      tot = vx + vy + longint'(ci);
      co  = (tot >= pw);
      tot = tot % pw;
      for (int i = 0; i < int'(D); i++) begin
        s[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      c = int'(ci);
      for (int i = 0; i < int'(D); i++) begin
        t = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + c;
        if (t > 9) begin
          s[4*i +: 4] = 4'((t + 6) % 16);
          c = 1;
        end else begin
          s[4*i +: 4] = 4'(t);
          c = 0;
        end
      end
      co = (c != 0);
    end
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(D); i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Call at a negedge with the DUT in IDLE or DONE.
  task automatic issue_k(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         input bit hold, input logic [W-1:0] es, input logic ec,
                         input logic ee);
    exp_t e;
    a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk);
    #1;
    e.s = es; e.co = ec; e.er = ee; e.cyc = cyc;
    sb.push_back(e);
    if (!hold) start = 1'b0;
  endtask

  // Scrambles the inputs while waiting so capture is exercised.
  task automatic wait_done();
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      n++;
    end while (!done && n < 50);
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done=1", n);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      bcnt = 0;
      prev_sum = sum;
    end else begin
      if (busy) begin
        bcnt++;
        chk("sum_stable_in_run", 64'(sum), 64'(prev_sum));
      end
      if (done) begin
        chk("busy_with_done", 64'(busy), 64'd0);
        chk("busy_length", 64'(bcnt), 64'(D));
        bcnt = 0;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 with no operation pending, required done=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", 64'(sum), 64'(e.s));
          chk("cout", 64'(cout), 64'(e.co));
          chk("err", 64'(err), 64'(e.er));
          chk("latency", 64'(cyc - e.cyc), 64'(D));
        end
      end
      prev_sum = sum;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] x, y, es;
    logic         ci, ec, ee;
    int unsigned  gap;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue_k(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0); wait_done();
    issue_k(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); wait_done();
    issue_k(16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0); wait_done();

    // start held through RUN and DONE: second op accepted straight from DONE
    issue_k(16'h4321, 16'h1111, 1'b1, 1'b1, 16'h5433, 1'b0, 1'b0); wait_done();
    issue_k(16'h2500, 16'h2500, 1'b0, 1'b0, 16'h5000, 1'b0, 1'b0); wait_done();

    // reset in the 2nd RUN cycle aborts the operation
    issue_k(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    issue_k(16'h0500, 16'h0500, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0); wait_done();
    issue_k(16'h000A, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b1); wait_done();
    issue_k(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0); wait_done();

    for (int n = 0; n < 200; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      x  = rand_bcd();
      y  = rand_bcd();
      ci = 1'($urandom);
      ref_add(x, y, ci, es, ec, ee);
      issue_k(x, y, ci, 1'b0, es, ec, ee);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
